// File: rtl/cola_buyer_pkg.sv
// Shared constants for the cola buyer and its vending responder: one-hot FSM
// states and the default price/gap/timeout so both sides agree on PRICE.
package cola_buyer_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE = 4'b0001;
    localparam state_t S_COIN = 4'b0010;
    localparam state_t S_GAP  = 4'b0100;
    localparam state_t S_WAIT = 4'b1000;

    localparam int PRICE_DEF   = 3;
    localparam int GAP_DEF     = 2;
    localparam int TIMEOUT_DEF = 8;
    localparam int NUM_W_DEF   = 4;

endpackage

// File: rtl/cola_buyer_if.sv
// Request/status and coin/cola signals of the cola buyer; master is the
// requester plus vending side, slave is the buyer itself.
interface cola_buyer_if #(
    parameter int NUM_W = cola_buyer_pkg::NUM_W_DEF
);
    logic             start;
    logic [NUM_W-1:0] buy_num;
    logic             po_money;
    logic             pi_cola;
    logic             busy;
    logic             done;
    logic             err;
    logic [NUM_W-1:0] cola_cnt;

    modport master (
        output start, buy_num, pi_cola,
        input  po_money, busy, done, err, cola_cnt
    );

    modport slave (
        input  start, buy_num, pi_cola,
        output po_money, busy, done, err, cola_cnt
    );
endinterface

// File: rtl/cola_buyer.sv
// Buys buy_num colas: PRICE coin pulses GAP cycles apart per item, then waits
// up to TIMEOUT cycles for the cola pulse. All outputs registered; start ignored while busy.
module cola_buyer
    import cola_buyer_pkg::*;
#(
    parameter int PRICE   = PRICE_DEF,
    parameter int GAP     = GAP_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int NUM_W   = NUM_W_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    cola_buyer_if.slave bus
);

    localparam int CW = $clog2(PRICE + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] COIN_LAST  = CW'(PRICE - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [TW-1:0] TIME_LAST  = TW'(TIMEOUT - 1);
    // With no gap configured, coins and the next item start back to back.
    localparam state_t        AFTER_COIN = (GAP > 0) ? S_GAP : S_COIN;

    state_t           state, state_nxt;
    logic [NUM_W-1:0] target;
    logic [NUM_W-1:0] cola_cnt_q;
    logic [CW-1:0]    coin_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [TW-1:0]    timer;
    logic             po_q, busy_q, done_q, err_q;
    logic             po_nxt, busy_nxt, done_nxt, err_nxt;
    logic             last_coin, last_cola, gap_over, timed_out;

    assign last_coin = (coin_cnt == COIN_LAST);
    assign last_cola = ((cola_cnt_q + NUM_W'(1)) == target);
    assign gap_over  = (gap_cnt == GAP_LAST);
    assign timed_out = (timer == TIME_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start && bus.buy_num != '0) state_nxt = S_COIN;
            S_COIN: begin
                if (bus.pi_cola)    state_nxt = S_IDLE;
                else if (last_coin) state_nxt = S_WAIT;
                else                state_nxt = AFTER_COIN;
            end
            S_GAP: begin
                if (bus.pi_cola)   state_nxt = S_IDLE;
                else if (gap_over) state_nxt = S_COIN;
            end
            S_WAIT: begin
                if (bus.pi_cola)    state_nxt = last_cola ? S_IDLE : AFTER_COIN;
                else if (timed_out) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are the registered image of the upcoming state and transition.
    always_comb begin
        po_nxt   = (state_nxt == S_COIN);
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = 1'b0;
        err_nxt  = 1'b0;
        case (state)
            S_IDLE:        done_nxt = bus.start && (bus.buy_num == '0);
            S_COIN, S_GAP: err_nxt  = bus.pi_cola;
            S_WAIT: begin
                done_nxt = bus.pi_cola && last_cola;
                err_nxt  = !bus.pi_cola && timed_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            po_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            po_q   <= po_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target     <= '0;
            cola_cnt_q <= '0;
            coin_cnt   <= '0;
            gap_cnt    <= '0;
            timer      <= '0;
        end else begin
            gap_cnt <= (state == S_GAP) ? gap_cnt + GW'(1) : '0;
            case (state)
                S_IDLE: if (bus.start) begin
                    cola_cnt_q <= '0;
                    coin_cnt   <= '0;
                    timer      <= '0;
                    if (bus.buy_num != '0) target <= bus.buy_num;
                end
                S_COIN: begin
                    if (last_coin) begin
                        coin_cnt <= '0;
                        timer    <= '0;
                    end else begin
                        coin_cnt <= coin_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    if (bus.pi_cola) cola_cnt_q <= cola_cnt_q + NUM_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.po_money = po_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.cola_cnt = cola_cnt_q;

endmodule

// File: tb/tb_cola_buyer.sv
// Bench for cola_buyer: cycle traces compared against a schedule computed
// arithmetically from price, gap, timeout and responder delays.
`timescale 1ns/1ps
module tb_cola_buyer;
    import cola_buyer_pkg::*;

    localparam int P    = PRICE_DEF;
    localparam int G    = GAP_DEF;
    localparam int T    = TIMEOUT_DEF;
    localparam int NW   = NUM_W_DEF;
    localparam int MAXC = 128;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cola_buyer_if #(.NUM_W(NW)) bus();

    cola_buyer #(.PRICE(P), .GAP(G), .TIMEOUT(T), .NUM_W(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [MAXC-1:0] po_log, busy_log, done_log, err_log;
    logic [MAXC-1:0] exp_po, exp_busy, exp_done, exp_err;
    int   exp_cnt;
    int   delay_q[$];   // responder delay after the last coin of each item, 0 = silent
    logic rst_po, rst_busy, rst_done, rst_err;

    // Expected schedule: coin j of an item at t + j*(G+1); cola d cycles after last coin.
    task automatic build_model(input int n, input int spur, input int rst_cyc);
        int t, last, d, fin;
        exp_po = '0; exp_busy = '0; exp_done = '0; exp_err = '0;
        exp_cnt = 0; fin = -1;
        if (n == 0) begin
            fin = 1;
            exp_done[1] = 1'b1;
        end else begin
            t = 1;
            for (int k = 0; k < n && fin < 0; k++) begin
                last = t + (P - 1) * (G + 1);
                for (int j = 0; j < P; j++)
                    if (spur < 0 || t + j * (G + 1) <= spur) exp_po[t + j * (G + 1)] = 1'b1;
                if (spur >= 0 && spur <= last) begin
                    fin = spur + 1;
                    exp_err[fin] = 1'b1;
                end else begin
                    d = (k < delay_q.size()) ? delay_q[k] : 0;
                    if (d == 0 || d > T) begin
                        fin = last + 1 + T;
                        exp_err[fin] = 1'b1;
                    end else begin
                        exp_cnt++;
                        if (exp_cnt == n) begin
                            fin = last + d + 1;
                            exp_done[fin] = 1'b1;
                        end else begin
                            t = last + d + G + 1;
                        end
                    end
                end
            end
            for (int c = 1; c < fin; c++) exp_busy[c] = 1'b1;
        end
        if (rst_cyc >= 0) begin
            for (int c = rst_cyc; c < MAXC; c++) begin
                exp_po[c] = 1'b0; exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_err[c] = 1'b0;
            end
            exp_cnt = 0;
        end
    endtask

    // Runs one purchase started in cycle 0; the responder reacts to observed coins.
    task automatic run(input int n, input int ncyc, input int spur, input int st2, input int rst_cyc);
        int pend[$];
        int item, coins;
        item = 0; coins = 0;
        po_log = '0; busy_log = '0; done_log = '0; err_log = '0;
        for (int c = 0; c < ncyc; c++) begin
            bus.start   = (c == 0) || (c == st2);
            bus.buy_num = (c == 0) ? NW'(n) : NW'($urandom_range(1, 15));
            bus.pi_cola = (c == spur);
            foreach (pend[i]) if (pend[i] == c) bus.pi_cola = 1'b1;
            if (rst_cyc >= 0 && c == rst_cyc + 2) rst_n = 1'b1;
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                rst_po = bus.po_money; rst_busy = bus.busy;
                rst_done = bus.done;   rst_err = bus.err;
                pend.delete();
            end
            @(negedge clk);
            po_log[c] = bus.po_money; busy_log[c] = bus.busy;
            done_log[c] = bus.done;   err_log[c] = bus.err;
            if (bus.po_money) begin
                coins++;
                if (coins % P == 0) begin
                    if (item < delay_q.size() && delay_q[item] > 0) pend.push_back(c + delay_q[item]);
                    item++;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.pi_cola = 1'b0;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'($urandom); bus.buy_num = NW'($urandom); bus.pi_cola = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({bus.po_money, bus.busy, bus.done, bus.err, bus.cola_cnt} !== '0) begin
                errors++;
                $display("FAIL reset_hold: outputs=%b required all zero", {bus.po_money, bus.busy, bus.done, bus.err, bus.cola_cnt});
            end
            @(posedge clk);
        end
        #1;
        bus.start = 1'b0; bus.pi_cola = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.po_money, bus.busy} !== 2'b00) begin
                errors++;
                $display("FAIL reset_release: po_money/busy=%b required 00", {bus.po_money, bus.busy});
            end
            @(posedge clk);
        end
        #1;
    endtask

    task automatic test_single;
        delay_q = {1};
        build_model(1, -1, -1);
        run(1, 14, -1, -1, -1);
        checks++; if (po_log[15:0] !== 16'h0092) begin errors++; $display("FAIL single_coin_cycles: got %h want 0092", po_log[15:0]); end
        checks++; if (done_log[15:0] !== 16'h0200) begin errors++; $display("FAIL single_done_cycle: got %h want 0200", done_log[15:0]); end
        checks++; if (busy_log !== exp_busy) begin errors++; $display("FAIL single_busy: got %h want %h", busy_log, exp_busy); end
        checks++; if (bus.cola_cnt !== NW'(exp_cnt)) begin errors++; $display("FAIL single_cnt: got %0d want %0d", bus.cola_cnt, exp_cnt); end
    endtask

    task automatic test_multi;
        delay_q = {1, 1, 1};
        build_model(3, -1, -1);
        run(3, 34, -1, -1, -1);
        checks++; if (po_log !== exp_po) begin errors++; $display("FAIL multi_po: got %h want %h", po_log, exp_po); end
        checks++; if (done_log !== exp_done || done_log[29] !== 1'b1) begin errors++; $display("FAIL multi_done: got %h want %h", done_log, exp_done); end
        checks++; if (bus.cola_cnt !== NW'(3)) begin errors++; $display("FAIL multi_cnt: got %0d want 3", bus.cola_cnt); end
    endtask

    task automatic test_timeout;
        delay_q = {0, 0};
        build_model(2, -1, -1);
        run(2, 22, -1, -1, -1);
        checks++; if (err_log !== exp_err || err_log[16] !== 1'b1) begin errors++; $display("FAIL timeout_err: got %h want %h", err_log, exp_err); end
        checks++; if (po_log !== exp_po) begin errors++; $display("FAIL timeout_po: got %h want %h", po_log, exp_po); end
        checks++; if (done_log !== '0) begin errors++; $display("FAIL timeout_done: got %h want 0", done_log); end
        checks++; if (bus.cola_cnt !== NW'(0)) begin errors++; $display("FAIL timeout_cnt: got %0d want 0", bus.cola_cnt); end
    endtask

    task automatic test_zero;
        delay_q = {};
        build_model(0, -1, -1);
        run(0, 5, -1, -1, -1);
        checks++; if (done_log !== exp_done) begin errors++; $display("FAIL zero_done: got %h want %h", done_log, exp_done); end
        checks++; if ({po_log, busy_log} !== '0) begin errors++; $display("FAIL zero_activity: po %h busy %h want 0", po_log, busy_log); end
    endtask

    task automatic test_start_busy;
        delay_q = {1};
        build_model(1, -1, -1);
        run(1, 16, -1, 5, -1);
        checks++; if ($countones(po_log) != P || po_log !== exp_po) begin errors++; $display("FAIL busy_start_coins: got %h want %h", po_log, exp_po); end
        checks++; if (done_log !== exp_done) begin errors++; $display("FAIL busy_start_done: got %h want %h", done_log, exp_done); end
    endtask

    task automatic test_spurious;
        delay_q = {1, 1};
        build_model(2, 2, -1);
        run(2, 10, 2, -1, -1);
        checks++; if (err_log !== exp_err || err_log[3] !== 1'b1) begin errors++; $display("FAIL spur_err: got %h want %h", err_log, exp_err); end
        checks++; if (po_log !== exp_po) begin errors++; $display("FAIL spur_po: got %h want %h", po_log, exp_po); end
        checks++; if (busy_log !== exp_busy) begin errors++; $display("FAIL spur_busy: got %h want %h", busy_log, exp_busy); end
    endtask

    task automatic test_reset_mid;
        int rc[2];
        rc[0] = 5; rc[1] = 7;
        foreach (rc[k]) begin
            delay_q = {1, 1};
            build_model(2, -1, rc[k]);
            run(2, rc[k] + 6, -1, -1, rc[k]);
            checks++;
            if ({rst_po, rst_busy, rst_done, rst_err} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_mid_immediate@%0d: po/busy/done/err=%b want 0000", rc[k], {rst_po, rst_busy, rst_done, rst_err});
            end
            checks++;
            if ({po_log, busy_log, done_log, err_log} !== {exp_po, exp_busy, exp_done, exp_err}) begin
                errors++;
                $display("FAIL reset_mid_trace@%0d: po %h busy %h done %h err %h", rc[k], po_log, busy_log, done_log, err_log);
            end
        end
    endtask

    task automatic test_random;
        int n, ncyc;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(0, 4);
            delay_q.delete();
            for (int k = 0; k < n; k++) delay_q.push_back($urandom_range(1, T + 1));
            ncyc = (n == 0) ? 4 : n * (1 + (P - 1) * (G + 1) + T + 1 + G) + 4;
            build_model(n, -1, -1);
            run(n, ncyc, -1, -1, -1);
            checks++;
            if ({po_log, busy_log, done_log, err_log} !== {exp_po, exp_busy, exp_done, exp_err}) begin
                errors++;
                $display("FAIL random_trace n=%0d: po %h/%h done %h/%h err %h/%h", n, po_log, exp_po, done_log, exp_done, err_log, exp_err);
            end
            checks++;
            if (bus.cola_cnt !== NW'(exp_cnt)) begin
                errors++;
                $display("FAIL random_cnt n=%0d: got %0d want %0d", n, bus.cola_cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.buy_num = '0; bus.pi_cola = 1'b0;
        test_reset;
        test_single;
        test_multi;
        test_timeout;
        test_zero;
        test_start_busy;
        test_spurious;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
